// File: rtl/volume_level_controller.sv
// Volume level controller: conditions the KEY/SW inputs and steps the attenuator level.
// Each step is confirmed against the attenuator's registered volume echo before the next is accepted.

module vlc_debounce #(
  parameter int   CYCLES   = 4,
  parameter logic IDLE_VAL = 1'b1
) (
  input  logic clock,
  input  logic resetn,
  input  logic raw,
  output logic stable
);
  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic          s1, s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      s1     <= IDLE_VAL;
      s2     <= IDLE_VAL;
      stable <= IDLE_VAL;
      cnt    <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      // Any agreement with the current debounced value restarts the count.
      if (s2 != stable) begin
        if (cnt == CW'(CYCLES - 1)) begin
          stable <= s2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module volume_level_controller #(
  parameter int         DEBOUNCE_CYCLES = 1000000,
  parameter int         ACK_TIMEOUT     = 16,
  parameter logic [1:0] RESET_LEVEL     = 2'b11
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       key_up_n,
  input  logic       key_down_n,
  input  logic       mute,
  input  logic [1:0] volume,
  output logic [1:0] level,
  output logic       busy,
  output logic       ack_error,
  output logic       muted
);
  localparam int         NUM_LANES = 3;
  localparam int         TW        = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  // Lane order: 0 = key_up_n, 1 = key_down_n, 2 = mute. Keys idle high, mute idles low.
  localparam logic [NUM_LANES-1:0] IDLE_VALS = 3'b011;

  typedef enum logic {ST_WAIT, ST_IDLE} state_t;

  logic [NUM_LANES-1:0] raw, db;
  logic [1:0]           key_db_q;
  logic                 up_evt, dn_evt;

  state_t               state, state_nxt;
  logic [1:0]           target, target_nxt, level_nxt, tgt_upd, eff;
  logic [TW-1:0]        timer, timer_nxt;
  logic                 err_nxt;

  assign raw = {mute, key_down_n, key_up_n};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    vlc_debounce #(
      .CYCLES  (DEBOUNCE_CYCLES),
      .IDLE_VAL(IDLE_VALS[g])
    ) u_db (
      .clock (clock),
      .resetn(resetn),
      .raw   (raw[g]),
      .stable(db[g])
    );
  end

  // Press = debounced released->pressed edge; releases are ignored.
  assign up_evt = key_db_q[0] & ~db[0];
  assign dn_evt = key_db_q[1] & ~db[1];
  assign muted  = db[2];

  always_ff @(posedge clock) begin
    if (!resetn) begin
      key_db_q  <= 2'b11;
      state     <= ST_WAIT;
      level     <= RESET_LEVEL;
      target    <= RESET_LEVEL;
      timer     <= '0;
      ack_error <= 1'b0;
    end else begin
      key_db_q  <= db[1:0];
      state     <= state_nxt;
      level     <= level_nxt;
      target    <= target_nxt;
      timer     <= timer_nxt;
      ack_error <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    level_nxt  = level;
    target_nxt = target;
    timer_nxt  = timer;
    err_nxt    = ack_error;
    busy       = 1'b0;
    tgt_upd    = target;
    eff        = level;
    case (state)
      ST_WAIT: begin
        busy = 1'b1;
        if (volume == level) begin
          state_nxt = ST_IDLE;
          err_nxt   = 1'b0;
          timer_nxt = '0;
        end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
          state_nxt = ST_IDLE;
          err_nxt   = 1'b1;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      ST_IDLE: begin
        // Simultaneous up/down cancel; both directions saturate.
        if (up_evt && !dn_evt && target != 2'd3) tgt_upd = target + 2'd1;
        if (dn_evt && !up_evt && target != 2'd0) tgt_upd = target - 2'd1;
        target_nxt = tgt_upd;
        eff        = db[2] ? 2'd0 : tgt_upd;
        if (eff != level) begin
          level_nxt = eff;
          state_nxt = ST_WAIT;
          timer_nxt = '0;
        end
      end
      default: state_nxt = ST_WAIT;
    endcase
  end
endmodule
